// File: rtl/preset_countdown.sv
// Preset countdown: loads a saturated 6-bit preset, decrements it on timebase
// ticks and emits a one-cycle done pulse at expiry. Binary and BCD views are registered.
module preset_countdown #(
  parameter int MAX_COUNT = 59
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [5:0] preset,
  input  logic       tick,
  input  logic       hold,
  output logic [5:0] count,
  output logic [3:0] tens,
  output logic [3:0] units,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, RUN, HOLD, EXPIRE} state_t;

  localparam logic [6:0] LIM = 7'(MAX_COUNT);

  state_t     r_state, w_state_nxt;
  logic [5:0] r_count, w_count_nxt;
  logic [3:0] r_tens, w_tens_nxt;
  logic [3:0] r_units, w_units_nxt;
  logic       r_busy, w_busy_nxt;
  logic       r_done, w_done_nxt;
  logic [5:0] w_load_val;
  logic [7:0] w_load_bcd;

  function automatic logic [5:0] sat_preset(input logic [5:0] p);
    if ({1'b0, p} > LIM) return LIM[5:0];
    return p;
  endfunction

  // Shift-and-add-3 binary to two-digit BCD; 6-bit input never exceeds 63.
  function automatic logic [7:0] to_bcd(input logic [5:0] v);
    logic [13:0] sh;
    sh = {8'd0, v};
    for (int i = 0; i < 6; i++) begin
      if (sh[9:6]   >= 4'd5) sh[9:6]   = sh[9:6]   + 4'd3;
      if (sh[13:10] >= 4'd5) sh[13:10] = sh[13:10] + 4'd3;
      sh = sh << 1;
    end
    return sh[13:6];
  endfunction

  assign w_load_val = sat_preset(preset);
  assign w_load_bcd = to_bcd(w_load_val);

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_tens_nxt  = r_tens;
    w_units_nxt = r_units;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    if (load) begin
      // A load overrides tick, hold and any pending expiry in the same cycle.
      w_count_nxt = w_load_val;
      w_tens_nxt  = w_load_bcd[7:4];
      w_units_nxt = w_load_bcd[3:0];
      if (w_load_val != 6'd0) begin
        w_state_nxt = RUN;
        w_busy_nxt  = 1'b1;
      end else begin
        w_state_nxt = EXPIRE;
        w_busy_nxt  = 1'b0;
      end
    end else begin
      unique case (r_state)
        IDLE: begin
          w_busy_nxt = 1'b0;
        end
        RUN: begin
          if (hold) begin
            w_state_nxt = HOLD;
          end else if (tick) begin
            if (r_count == 6'd1) begin
              w_count_nxt = 6'd0;
              w_tens_nxt  = 4'd0;
              w_units_nxt = 4'd0;
              w_busy_nxt  = 1'b0;
              w_done_nxt  = 1'b1;
              w_state_nxt = IDLE;
            end else begin
              w_count_nxt = r_count - 6'd1;
              if (r_units == 4'd0) begin
                w_units_nxt = 4'd9;
                w_tens_nxt  = r_tens - 4'd1;
              end else begin
                w_units_nxt = r_units - 4'd1;
              end
            end
          end
        end
        HOLD: begin
          if (!hold) w_state_nxt = RUN;
        end
        EXPIRE: begin
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
          w_state_nxt = IDLE;
        end
        default: begin
          w_state_nxt = IDLE;
          w_busy_nxt  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_count <= 6'd0;
      r_tens  <= 4'd0;
      r_units <= 4'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_tens  <= w_tens_nxt;
      r_units <= w_units_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign count = r_count;
  assign tens  = r_tens;
  assign units = r_units;
  assign busy  = r_busy;
  assign done  = r_done;

endmodule

// File: tb/tb_preset_countdown.sv
// Scoreboard bench for preset_countdown: each stimulus row pushes its expected
// outputs, which are popped and compared one clock edge later.
module tb_preset_countdown;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       load = 1'b0;
  logic [5:0] preset = 6'd0;
  logic       tick = 1'b0;
  logic       hold = 1'b0;
  logic [5:0] count;
  logic [3:0] tens;
  logic [3:0] units;
  logic       busy;
  logic       done;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic       ld;
    logic [5:0] pre;
    logic       tk;
    logic       hd;
    logic [5:0] c;
    logic [3:0] t;
    logic [3:0] u;
    logic       b;
    logic       d;
  } stim_t;

  stim_t sb[$];

  preset_countdown #(.MAX_COUNT(59)) dut (
    .clk(clk), .reset(reset), .load(load), .preset(preset), .tick(tick),
    .hold(hold), .count(count), .tens(tens), .units(units), .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  function automatic stim_t mk(input logic ld, input int pre, input logic tk,
                               input logic hd, input int c, input logic b,
                               input logic d);
    stim_t s;
    s.ld = ld; s.pre = 6'(pre); s.tk = tk; s.hd = hd;
    s.c = 6'(c); s.t = 4'(c / 10); s.u = 4'(c % 10); s.b = b; s.d = d;
    return s;
  endfunction

  task automatic test_reset();
    stim_t rows[$];
    stim_t e;
    #1 reset = 1'b1;
    #1;
    vectors++;
    if ({count, tens, units, busy, done} !== 15'd0) begin
      miscompares++;
      $display("FAIL reset_init: got %0d %0d %0d %0b %0b, want all zero", count, tens, units, busy, done);
    end
    @(posedge clk); #1 reset = 1'b0;
    rows.push_back(mk(1, 20, 0, 0, 20, 1, 0));
    foreach (rows[i]) begin
      load = rows[i].ld; preset = rows[i].pre; tick = rows[i].tk; hold = rows[i].hd;
      sb.push_back(rows[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      vectors++;
      if ({count, tens, units, busy, done} !== {e.c, e.t, e.u, e.b, e.d}) begin
        miscompares++;
        $display("FAIL reset_load20 row %0d: got %0d %0d %0d %0b %0b, want %0d %0d %0d %0b %0b",
                 i, count, tens, units, busy, done, e.c, e.t, e.u, e.b, e.d);
      end
    end
    load = 1'b0;
    #2 reset = 1'b1;
    #1;
    vectors++;
    if ({count, tens, units, busy, done} !== 15'd0) begin
      miscompares++;
      $display("FAIL reset_midrun: got %0d %0d %0d %0b %0b, want all zero", count, tens, units, busy, done);
    end
    @(posedge clk); #1 reset = 1'b0;
    rows.delete();
    for (int k = 0; k < 3; k++) rows.push_back(mk(0, 0, 1, 0, 0, 0, 0));
    foreach (rows[i]) begin
      load = rows[i].ld; preset = rows[i].pre; tick = rows[i].tk; hold = rows[i].hd;
      sb.push_back(rows[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      vectors++;
      if ({count, tens, units, busy, done} !== {e.c, e.t, e.u, e.b, e.d}) begin
        miscompares++;
        $display("FAIL reset_ticks row %0d: got %0d %0d %0d %0b %0b, want %0d %0d %0d %0b %0b",
                 i, count, tens, units, busy, done, e.c, e.t, e.u, e.b, e.d);
      end
    end
    tick = 1'b0;
  endtask

  task automatic test_countdown();
    stim_t rows[$];
    stim_t e;
    rows.push_back(mk(1, 5, 0, 0, 5, 1, 0));
    for (int c = 4; c >= 0; c--) begin
      for (int k = 0; k < 3; k++) rows.push_back(mk(0, 0, 0, 0, c + 1, 1, 0));
      rows.push_back(mk(0, 0, 1, 0, c, c != 0, c == 0));
    end
    rows.push_back(mk(0, 0, 1, 0, 0, 0, 0));
    rows.push_back(mk(0, 0, 0, 1, 0, 0, 0));
    foreach (rows[i]) begin
      load = rows[i].ld; preset = rows[i].pre; tick = rows[i].tk; hold = rows[i].hd;
      sb.push_back(rows[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      vectors++;
      if ({count, tens, units, busy, done} !== {e.c, e.t, e.u, e.b, e.d}) begin
        miscompares++;
        $display("FAIL countdown5 row %0d: got %0d %0d %0d %0b %0b, want %0d %0d %0d %0b %0b",
                 i, count, tens, units, busy, done, e.c, e.t, e.u, e.b, e.d);
      end
    end
    load = 1'b0; tick = 1'b0; hold = 1'b0;
  endtask

  task automatic test_bcd_sat();
    stim_t rows[$];
    stim_t e;
    rows.push_back(mk(1, 30, 0, 0, 30, 1, 0));
    rows.push_back(mk(0, 0, 1, 0, 29, 1, 0));
    rows.push_back(mk(0, 0, 1, 0, 28, 1, 0));
    rows.push_back(mk(1, 63, 0, 0, 59, 1, 0));
    rows.push_back(mk(0, 0, 1, 0, 58, 1, 0));
    rows.push_back(mk(1, 60, 1, 0, 59, 1, 0));
    rows.push_back(mk(1, 10, 0, 0, 10, 1, 0));
    rows.push_back(mk(0, 0, 1, 0, 9, 1, 0));
    foreach (rows[i]) begin
      load = rows[i].ld; preset = rows[i].pre; tick = rows[i].tk; hold = rows[i].hd;
      sb.push_back(rows[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      vectors++;
      if ({count, tens, units, busy, done} !== {e.c, e.t, e.u, e.b, e.d}) begin
        miscompares++;
        $display("FAIL bcd_sat row %0d: got %0d %0d %0d %0b %0b, want %0d %0d %0d %0b %0b",
                 i, count, tens, units, busy, done, e.c, e.t, e.u, e.b, e.d);
      end
    end
    load = 1'b0; tick = 1'b0;
  endtask

  task automatic test_zero_preset();
    stim_t rows[$];
    stim_t e;
    rows.push_back(mk(1, 0, 0, 0, 0, 0, 0));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 1));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    rows.push_back(mk(0, 0, 1, 0, 0, 0, 0));
    foreach (rows[i]) begin
      load = rows[i].ld; preset = rows[i].pre; tick = rows[i].tk; hold = rows[i].hd;
      sb.push_back(rows[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      vectors++;
      if ({count, tens, units, busy, done} !== {e.c, e.t, e.u, e.b, e.d}) begin
        miscompares++;
        $display("FAIL zero_preset row %0d: got %0d %0d %0d %0b %0b, want %0d %0d %0d %0b %0b",
                 i, count, tens, units, busy, done, e.c, e.t, e.u, e.b, e.d);
      end
    end
    load = 1'b0; tick = 1'b0;
  endtask

  task automatic test_hold();
    stim_t rows[$];
    stim_t e;
    rows.push_back(mk(1, 22, 0, 0, 22, 1, 0));
    for (int k = 0; k < 3; k++) rows.push_back(mk(0, 0, 1, 1, 22, 1, 0));
    rows.push_back(mk(0, 0, 0, 0, 22, 1, 0));
    rows.push_back(mk(0, 0, 1, 0, 21, 1, 0));
    rows.push_back(mk(1, 15, 1, 0, 15, 1, 0));
    rows.push_back(mk(0, 0, 1, 0, 14, 1, 0));
    rows.push_back(mk(0, 0, 0, 1, 14, 1, 0));
    rows.push_back(mk(1, 7, 0, 1, 7, 1, 0));
    rows.push_back(mk(0, 0, 1, 0, 6, 1, 0));
    foreach (rows[i]) begin
      load = rows[i].ld; preset = rows[i].pre; tick = rows[i].tk; hold = rows[i].hd;
      sb.push_back(rows[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      vectors++;
      if ({count, tens, units, busy, done} !== {e.c, e.t, e.u, e.b, e.d}) begin
        miscompares++;
        $display("FAIL hold row %0d: got %0d %0d %0d %0b %0b, want %0d %0d %0d %0b %0b",
                 i, count, tens, units, busy, done, e.c, e.t, e.u, e.b, e.d);
      end
    end
    load = 1'b0; tick = 1'b0; hold = 1'b0;
  endtask

  task automatic test_back_to_back();
    stim_t rows[$];
    stim_t e;
    rows.push_back(mk(1, 1, 0, 0, 1, 1, 0));
    rows.push_back(mk(1, 3, 1, 0, 3, 1, 0));
    rows.push_back(mk(0, 0, 1, 0, 2, 1, 0));
    rows.push_back(mk(1, 0, 0, 0, 0, 0, 0));
    rows.push_back(mk(1, 2, 0, 0, 2, 1, 0));
    rows.push_back(mk(0, 0, 1, 0, 1, 1, 0));
    rows.push_back(mk(0, 0, 1, 0, 0, 0, 1));
    rows.push_back(mk(0, 0, 1, 0, 0, 0, 0));
    rows.push_back(mk(1, 1, 0, 0, 1, 1, 0));
    rows.push_back(mk(0, 0, 1, 0, 0, 0, 1));
    rows.push_back(mk(1, 4, 0, 0, 4, 1, 0));
    foreach (rows[i]) begin
      load = rows[i].ld; preset = rows[i].pre; tick = rows[i].tk; hold = rows[i].hd;
      sb.push_back(rows[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      vectors++;
      if ({count, tens, units, busy, done} !== {e.c, e.t, e.u, e.b, e.d}) begin
        miscompares++;
        $display("FAIL back_to_back row %0d: got %0d %0d %0d %0b %0b, want %0d %0d %0d %0b %0b",
                 i, count, tens, units, busy, done, e.c, e.t, e.u, e.b, e.d);
      end
    end
    load = 1'b0; tick = 1'b0;
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_bcd_sat();
    test_zero_preset();
    test_hold();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
